btn_preset_pulse_gen: RTL

//  Conditions one raw push-button input into a clean, debounced level and a single-cycle

---
 rtl/btn_preset_pulse_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/btn_preset_pulse_gen.sv
// btn_preset_pulse_gen: push-button synchronizer, debouncer and press/release pulse generator
//   i_clk_20mhz         system clock, all logic on rising edge
//   i_rst_20mhz         synchronous active-high reset
//   i_btn_raw           asynchronous raw button pin
//   o_btn_level         debounced level, 1 = pressed
//   o_btn_press_pulse   one-cycle pulse per accepted press (and per auto-repeat)
//   o_btn_release_pulse one-cycle pulse per accepted release
// Define BTN_AUTO_REPEAT_EN to enable auto-repeat press pulses while held.
module btn_preset_pulse_gen #(
    parameter int unsigned parm_debounce_cycles      = 200000,
    parameter logic        parm_active_low           = 1'b0,
    parameter int unsigned parm_repeat_delay_cycles  = 10000000,
    parameter int unsigned parm_repeat_period_cycles = 4000000
) (
    input  logic i_clk_20mhz,
    input  logic i_rst_20mhz,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_btn_press_pulse,
    output logic o_btn_release_pulse
);
    localparam int unsigned MAX_DR = (parm_debounce_cycles > parm_repeat_delay_cycles) ?
                                     parm_debounce_cycles : parm_repeat_delay_cycles;
    localparam int unsigned MAX_P  = (MAX_DR > parm_repeat_period_cycles) ?
                                     MAX_DR : parm_repeat_period_cycles;
    localparam int CW = $clog2(MAX_P) + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t DB_LAST = cnt_t'(parm_debounce_cycles - 1);

    typedef enum logic [1:0] {ST_RELEASED, ST_PRESS_WAIT, ST_PRESSED, ST_RELEASE_WAIT} state_t;

    logic [1:0] sync_q;
    logic       btn_sync;
    state_t     state, state_nx;
    cnt_t       db_cnt, db_cnt_nx;
    logic       db_done;
    logic       level_nx, press_nx, release_nx;
    logic       rep_fire;

    // Two-flop synchronizer; resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz)
            sync_q <= {2{parm_active_low}};
        else
            sync_q <= {sync_q[0], i_btn_raw};
    end

    assign btn_sync = sync_q[1] ^ parm_active_low;
    assign db_done  = db_cnt == DB_LAST;

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state               <= ST_RELEASED;
            db_cnt              <= '0;
            o_btn_level         <= 1'b0;
            o_btn_press_pulse   <= 1'b0;
            o_btn_release_pulse <= 1'b0;
        end else begin
            state               <= state_nx;
            db_cnt              <= db_cnt_nx;
            o_btn_level         <= level_nx;
            o_btn_press_pulse   <= press_nx;
            o_btn_release_pulse <= release_nx;
        end
    end

    // The debounce counter only advances inside the two wait states; every transition clears it.
    always_comb begin
        state_nx   = state;
        db_cnt_nx  = db_cnt + cnt_t'(1);
        level_nx   = o_btn_level;
        press_nx   = rep_fire;
        release_nx = 1'b0;
        unique case (state)
            ST_RELEASED: begin
                db_cnt_nx = '0;
                if (btn_sync)
                    state_nx = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nx  = ST_RELEASED;
                    db_cnt_nx = '0;
                end else if (db_done) begin
                    state_nx  = ST_PRESSED;
                    db_cnt_nx = '0;
                    level_nx  = 1'b1;
                    press_nx  = 1'b1;
                end
            end
            ST_PRESSED: begin
                db_cnt_nx = '0;
                if (!btn_sync)
                    state_nx = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_nx  = ST_PRESSED;
                    db_cnt_nx = '0;
                end else if (!btn_sync && db_done) begin
                    state_nx   = ST_RELEASED;
                    db_cnt_nx  = '0;
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                end
            end
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam cnt_t DLY_LAST = cnt_t'(parm_repeat_delay_cycles - 1);
    localparam cnt_t PER_LAST = cnt_t'(parm_repeat_period_cycles - 1);

    cnt_t rep_cnt;
    logic rep_periodic;

    // First repeat waits the long delay, later ones the shorter period; any exit from
    // ST_PRESSED (including a release bounce) rearms the long delay.
    assign rep_fire = (state == ST_PRESSED) && btn_sync &&
                      (rep_cnt == (rep_periodic ? PER_LAST : DLY_LAST));

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz || state != ST_PRESSED || !btn_sync) begin
            rep_cnt      <= '0;
            rep_periodic <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt      <= '0;
            rep_periodic <= 1'b1;
        end else begin
            rep_cnt      <= rep_cnt + cnt_t'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule
